rx_mac_analy: RTL and testbench
===============================

Name:
rx_mac_analy

Overview:
- Receive-side Ethernet MAC header parser on a 32-bit word stream, placed between the receive MAC/PHY front end and the IP and ARP processing blocks.
- Strips the 16-byte header: 2 pad bytes, destination MAC, source MAC and EtherType.
- Checks the destination MAC and extracts the source (PC) MAC.
- Routes the payload to the IP output stream or the ARP output stream according to EtherType.

Parameters:
- DATA_W, 32, stream data width (fixed 32 for this design).
- MAC_W, 48, MAC address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-high (1 = reset asserted).
- cfg_mac_local  input  MAC_W  local MAC address, static during a frame.
- rx_data  input  DATA_W  frame word; first byte in bits [31:24].
- rx_vld  input  1  rx_data valid.
- rx_sop  input  1  first word of frame; qualified by rx_vld.
- rx_eop  input  1  last word of frame; qualified by rx_vld.
- rx_mod  input  2  invalid bytes in the last word (0 = all 4 valid); meaningful only with rx_eop.
- ip_data  output  DATA_W  IP payload word.
- ip_vld / ip_sop / ip_eop  output  1 each  IP stream valid, first-word and last-word flags.
- ip_mod  output  2  invalid bytes in the last IP word.
- arp_data / arp_vld / arp_sop / arp_eop / arp_mod  output  as the IP stream  ARP stream.
- get_mac_pc  output  MAC_W  source MAC of the most recent frame.
- flag_mac_err  output  1  destination MAC of the current/last frame is rejected.
- flag_type  output  2  EtherType class: 0 = other, 1 = IP (0x0800), 2 = ARP (0x0806).

Behaviour:
- Reset (rst_n = 1, asynchronous): every output is 0, the word counter is 0 and the state is IDLE.
- Word counter:
  - Counts accepted words (rx_vld = 1 only); gaps in rx_vld are allowed.
  - rx_vld with rx_sop sets the word index to 0; the counter then saturates at 4.
  - A sop arriving mid-frame restarts parsing.
- Header layout, by word index:
  - w0: [31:16] pad (ignored), [15:0] dst MAC[47:32].
  - w1: dst MAC[31:0].
  - w2: src MAC[47:16].
  - w3: [31:16] src MAC[15:0], [15:0] EtherType.
  - w4 onwards: payload.
- State machine:
  - IDLE -> HDR on sop.
  - HDR -> PAY after w3 if the frame is not ended.
  - Any state -> IDLE on eop.
  - An eop at or before w3 produces no output-stream activity.
- Destination MAC check:
  - Evaluated at w1 from the w0/w1 fields; result registered on the next clock.
  - Accept if dst == cfg_mac_local or dst == 48'hFFFF_FFFF_FFFF.
  - flag_mac_err = 1 on rejection; held until the next frame's w1.
- get_mac_pc:
  - [47:16] is loaded on the clock after w2; [15:0] is loaded on the clock after w3.
  - Captured for every frame, including rejected ones; held between frames.
- flag_type:
  - Registered on the clock after w3 (1 = 0x0800, 2 = 0x0806, 0 = other).
  - Held until the next frame's w3.
- Payload routing:
  - Applies only to accepted frames.
  - Each valid payload word appears on exactly one stream one clock after input (registered), with data unchanged.
  - IP if EtherType = 0x0800, ARP if EtherType = 0x0806; otherwise the payload is dropped.
  - Rejected frames are dropped entirely.
- Output flags:
  - *_sop = 1 on the first payload word (w4).
  - *_eop mirrors rx_eop.
  - *_mod = rx_mod when eop, else 0.
- Inactive-stream outputs: when no payload word is issued, vld/sop/eop are 0 and data/mod hold their last value.
- The IP and ARP streams are never active in the same cycle.
- No backpressure; the block must accept one word per clock continuously.

Test Plan:
- Setup for all cases: cfg_mac_local = 48'h2c0203040507; each frame is 5 words, sent back to back.
- Case 1 — wrong MAC, ARP. Frame {00001c02, 03040507, 08090a0b, 0c0d0806, 12131415}:
  - Expect flag_mac_err = 1 and no arp/ip vld.
  - Expect get_mac_pc = 48'h08090a0b0000 one clock after w2, then 48'h08090a0b0c0d.
- Case 2 — wrong MAC, IP. Frame {00001c02, 03040507, 08090a0b, 0c0d0800, 10111213}:
  - Expect flag_mac_err = 1, flag_type = 1 and no ip_vld.
- Case 3 — correct MAC, type 0801. Frame {00002c02, 03040507, 08090a0b, 0c0d0801, 10111213}:
  - Expect flag_mac_err = 0, flag_type = 0 and no output streams.
- Case 4 — correct MAC, ARP, rx_mod = 3 on the last word. Frame {00002c02, 03040507, 08090a0b, 0c0d0806, 10111213}:
  - One clock after w4, expect arp_vld = arp_sop = arp_eop = 1, arp_data = 32'h10111213, arp_mod = 3 and flag_type = 2.
- Case 5 — correct MAC, IP, rx_mod = 0. Same frame with EtherType 0800:
  - Expect ip_vld = ip_sop = ip_eop = 1, ip_data = 32'h10111213, ip_mod = 0 and flag_type = 1.
- Case 6 — robustness:
  - Insert rx_vld gaps inside a header: parsing result is unchanged.
  - Send a 3-word frame: no stream output.
  - Assert rst_n mid-payload: all outputs 0 immediately.
  - Broadcast destination FFFFFFFFFFFF with ARP type: payload forwarded on the ARP stream.

Source files
------------

// File: rtl/rx_mac_analy.sv
// Receive MAC header parser: strips pad/dst/src/EtherType and steers the
// payload of accepted frames to the IP or ARP stream.
module rx_mac_analy #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MAC_W  = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MAC_W-1:0]  cfg_mac_local,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_vld,
  input  logic              rx_sop,
  input  logic              rx_eop,
  input  logic [1:0]        rx_mod,
  output logic [DATA_W-1:0] ip_data,
  output logic              ip_vld,
  output logic              ip_sop,
  output logic              ip_eop,
  output logic [1:0]        ip_mod,
  output logic [DATA_W-1:0] arp_data,
  output logic              arp_vld,
  output logic              arp_sop,
  output logic              arp_eop,
  output logic [1:0]        arp_mod,
  output logic [MAC_W-1:0]  get_mac_pc,
  output logic              flag_mac_err,
  output logic [1:0]        flag_type
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] IDX_PAY = CNT_W'(4);
  localparam logic [1:0] TYPE_OTHER = 2'd0;
  localparam logic [1:0] TYPE_IP    = 2'd1;
  localparam logic [1:0] TYPE_ARP   = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       dst_hi_q, dst_hi_d;
  logic              first_q, first_d;
  logic              mac_err_q, mac_err_d;
  logic [1:0]        type_q, type_d;
  logic [MAC_W-1:0]  mac_pc_q, mac_pc_d;
  logic [DATA_W-1:0] ip_data_q, ip_data_d, arp_data_q, arp_data_d;
  logic              ip_vld_q, ip_vld_d, ip_sop_q, ip_sop_d, ip_eop_q, ip_eop_d;
  logic              arp_vld_q, arp_vld_d, arp_sop_q, arp_sop_d, arp_eop_q, arp_eop_d;
  logic [1:0]        ip_mod_q, ip_mod_d, arp_mod_q, arp_mod_d;

  logic [CNT_W-1:0]  cur_idx;
  logic              take;
  logic [MAC_W-1:0]  dst_mac;
  logic [1:0]        out_mod;

  // Next state, header capture and payload steering
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dst_hi_d   = dst_hi_q;
    first_d    = first_q;
    mac_err_d  = mac_err_q;
    type_d     = type_q;
    mac_pc_d   = mac_pc_q;
    ip_data_d  = ip_data_q;
    ip_mod_d   = ip_mod_q;
    ip_vld_d   = 1'b0;
    ip_sop_d   = 1'b0;
    ip_eop_d   = 1'b0;
    arp_data_d = arp_data_q;
    arp_mod_d  = arp_mod_q;
    arp_vld_d  = 1'b0;
    arp_sop_d  = 1'b0;
    arp_eop_d  = 1'b0;

    cur_idx = rx_sop ? '0 : cnt_q;
    take    = rx_vld && (rx_sop || (state_q != S_IDLE));
    dst_mac = {dst_hi_q, rx_data};
    out_mod = rx_eop ? rx_mod : 2'd0;

    if (take) begin
      cnt_d = (cur_idx >= IDX_PAY) ? IDX_PAY : cur_idx + CNT_W'(1);

      unique case (cur_idx)
        CNT_W'(0): dst_hi_d = rx_data[15:0];
        CNT_W'(1): mac_err_d = !((dst_mac == cfg_mac_local) || (dst_mac == {MAC_W{1'b1}}));
        CNT_W'(2): mac_pc_d[MAC_W-1:16] = rx_data;
        CNT_W'(3): begin
          mac_pc_d[15:0] = rx_data[31:16];
          first_d        = 1'b1;
          if (rx_data[15:0] == 16'h0800)      type_d = TYPE_IP;
          else if (rx_data[15:0] == 16'h0806) type_d = TYPE_ARP;
          else                                type_d = TYPE_OTHER;
        end
        default: begin
          // Payload: type_q/mac_err_q already hold this frame's header result
          if (state_q == S_PAY) begin
            first_d = 1'b0;
            if (!mac_err_q && (type_q == TYPE_IP)) begin
              ip_vld_d  = 1'b1;
              ip_sop_d  = first_q;
              ip_eop_d  = rx_eop;
              ip_data_d = rx_data;
              ip_mod_d  = out_mod;
            end else if (!mac_err_q && (type_q == TYPE_ARP)) begin
              arp_vld_d  = 1'b1;
              arp_sop_d  = first_q;
              arp_eop_d  = rx_eop;
              arp_data_d = rx_data;
              arp_mod_d  = out_mod;
            end
          end
        end
      endcase

      if (rx_eop)                                           state_d = S_IDLE;
      else if (rx_sop)                                      state_d = S_HDR;
      else if ((state_q == S_HDR) && (cur_idx == CNT_W'(3))) state_d = S_PAY;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dst_hi_q   <= '0;
      first_q    <= 1'b0;
      mac_err_q  <= 1'b0;
      type_q     <= TYPE_OTHER;
      mac_pc_q   <= '0;
      ip_data_q  <= '0;
      ip_vld_q   <= 1'b0;
      ip_sop_q   <= 1'b0;
      ip_eop_q   <= 1'b0;
      ip_mod_q   <= '0;
      arp_data_q <= '0;
      arp_vld_q  <= 1'b0;
      arp_sop_q  <= 1'b0;
      arp_eop_q  <= 1'b0;
      arp_mod_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dst_hi_q   <= dst_hi_d;
      first_q    <= first_d;
      mac_err_q  <= mac_err_d;
      type_q     <= type_d;
      mac_pc_q   <= mac_pc_d;
      ip_data_q  <= ip_data_d;
      ip_vld_q   <= ip_vld_d;
      ip_sop_q   <= ip_sop_d;
      ip_eop_q   <= ip_eop_d;
      ip_mod_q   <= ip_mod_d;
      arp_data_q <= arp_data_d;
      arp_vld_q  <= arp_vld_d;
      arp_sop_q  <= arp_sop_d;
      arp_eop_q  <= arp_eop_d;
      arp_mod_q  <= arp_mod_d;
    end
  end

  assign ip_data      = ip_data_q;
  assign ip_vld       = ip_vld_q;
  assign ip_sop       = ip_sop_q;
  assign ip_eop       = ip_eop_q;
  assign ip_mod       = ip_mod_q;
  assign arp_data     = arp_data_q;
  assign arp_vld      = arp_vld_q;
  assign arp_sop      = arp_sop_q;
  assign arp_eop      = arp_eop_q;
  assign arp_mod      = arp_mod_q;
  assign get_mac_pc   = mac_pc_q;
  assign flag_mac_err = mac_err_q;
  assign flag_type    = type_q;

endmodule

// File: tb/tb_rx_mac_analy.sv
// Scoreboard bench for rx_mac_analy: directed header cases plus random frames
// with valid gaps, checked against a frame-level reference model.
module tb_rx_mac_analy;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MAC_W  = 48;
  localparam logic [MAC_W-1:0] LOCAL_MAC = 48'h2c0203040507;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [MAC_W-1:0]  cfg_mac_local;
  logic [DATA_W-1:0] rx_data;
  logic rx_vld, rx_sop, rx_eop;
  logic [1:0] rx_mod;
  logic [DATA_W-1:0] ip_data, arp_data;
  logic ip_vld, ip_sop, ip_eop, arp_vld, arp_sop, arp_eop;
  logic [1:0] ip_mod, arp_mod;
  logic [MAC_W-1:0] get_mac_pc;
  logic flag_mac_err;
  logic [1:0] flag_type;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t ip_q[$];
  beat_t arp_q[$];

  // Reference model state (frame level)
  logic [47:0] m_pc;
  logic        m_err;
  logic [1:0]  m_type;

  logic [35:0] ip_last, arp_last;

  always #5 clk = ~clk;

  rx_mac_analy #(.DATA_W(DATA_W), .MAC_W(MAC_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mac_local(cfg_mac_local),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_mod(rx_mod),
    .ip_data(ip_data), .ip_vld(ip_vld), .ip_sop(ip_sop), .ip_eop(ip_eop), .ip_mod(ip_mod),
    .arp_data(arp_data), .arp_vld(arp_vld), .arp_sop(arp_sop), .arp_eop(arp_eop), .arp_mod(arp_mod),
    .get_mac_pc(get_mac_pc), .flag_mac_err(flag_mac_err), .flag_type(flag_type)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a stream is valid
  always @(negedge clk) begin
    if (rst_n) begin
      ip_last  <= '0;
      arp_last <= '0;
    end else begin
      check("exclusive", 64'(ip_vld & arp_vld), 64'd0);
      if (ip_vld) begin
        if (ip_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ip_unexpected: got %0h expected none", ip_data);
        end else begin
          check("ip_beat", 64'({ip_data, ip_sop, ip_eop, ip_mod}), 64'(ip_q.pop_front()));
        end
        ip_last <= {ip_data, 2'b00, ip_mod};
      end else begin
        check("ip_idle", 64'({ip_data, ip_sop, ip_eop, ip_mod}), 64'(ip_last));
      end
      if (arp_vld) begin
        if (arp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL arp_unexpected: got %0h expected none", arp_data);
        end else begin
          check("arp_beat", 64'({arp_data, arp_sop, arp_eop, arp_mod}), 64'(arp_q.pop_front()));
        end
        arp_last <= {arp_data, 2'b00, arp_mod};
      end else begin
        check("arp_idle", 64'({arp_data, arp_sop, arp_eop, arp_mod}), 64'(arp_last));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ip"},  64'({ip_data, ip_vld, ip_sop, ip_eop, ip_mod}), 64'd0);
    check({tag, "_arp"}, 64'({arp_data, arp_vld, arp_sop, arp_eop, arp_mod}), 64'd0);
    check({tag, "_pc"},  64'(get_mac_pc), 64'd0);
    check({tag, "_flags"}, 64'({flag_mac_err, flag_type}), 64'd0);
  endtask

  // Drives one frame and updates the model; header results are checked as they land
  task automatic send(input logic [31:0] w[$], input logic [1:0] last_mod,
                      input int gap_pct, input bit no_eop);
    int n;
    logic [47:0] dst;
    logic [15:0] et;
    bit last;
    n = w.size();
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        rx_vld = 1'b0; rx_data = $urandom; rx_sop = 1'($urandom);
        rx_eop = 1'($urandom); rx_mod = 2'($urandom);
        @(posedge clk); #1;
      end
      last    = (i == n - 1) && !no_eop;
      rx_vld  = 1'b1;
      rx_data = w[i];
      rx_sop  = (i == 0);
      rx_eop  = last;
      rx_mod  = last ? last_mod : 2'($urandom);
      if (i >= 4 && !m_err) begin
        if (m_type == 2'd1) ip_q.push_back({w[i], i == 4, last, last ? last_mod : 2'd0});
        if (m_type == 2'd2) arp_q.push_back({w[i], i == 4, last, last ? last_mod : 2'd0});
      end
      @(posedge clk); #1;
      if (i == 1) begin
        dst   = {w[0][15:0], w[1]};
        m_err = !((dst == LOCAL_MAC) || (dst == 48'hFFFF_FFFF_FFFF));
        check("mac_err_w1", 64'(flag_mac_err), 64'(m_err));
      end
      if (i == 2) begin
        m_pc[47:16] = w[2];
        check("mac_pc_w2", 64'(get_mac_pc), 64'(m_pc));
      end
      if (i == 3) begin
        m_pc[15:0] = w[3][31:16];
        et = w[3][15:0];
        m_type = (et == 16'h0800) ? 2'd1 : (et == 16'h0806) ? 2'd2 : 2'd0;
        check("mac_pc_w3", 64'(get_mac_pc), 64'(m_pc));
        check("type_w3", 64'(flag_type), 64'(m_type));
      end
    end
    rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    check("frame_flags", 64'({flag_mac_err, flag_type}), 64'({m_err, m_type}));
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    ip_q.delete();
    arp_q.delete();
    m_pc = '0; m_err = 1'b0; m_type = 2'd0;
    rst_n = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    logic [47:0] dst;
    logic [15:0] et;
    int len, sel;
    cfg_mac_local = LOCAL_MAC;
    rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_mod = 2'd0; rx_data = '0;
    do_reset();

    // Directed cases
    w = '{32'h00001c02, 32'h03040507, 32'h08090a0b, 32'h0c0d0806, 32'h12131415};
    send(w, 2'd0, 0, 1'b0);
    w = '{32'h00001c02, 32'h03040507, 32'h08090a0b, 32'h0c0d0800, 32'h10111213};
    send(w, 2'd0, 0, 1'b0);
    w = '{32'h00002c02, 32'h03040507, 32'h08090a0b, 32'h0c0d0801, 32'h10111213};
    send(w, 2'd0, 0, 1'b0);
    w = '{32'h00002c02, 32'h03040507, 32'h08090a0b, 32'h0c0d0806, 32'h10111213};
    send(w, 2'd3, 0, 1'b0);
    w = '{32'h00002c02, 32'h03040507, 32'h08090a0b, 32'h0c0d0800, 32'h10111213};
    send(w, 2'd0, 0, 1'b0);
    w = '{32'h00002c02, 32'h03040507, 32'h08090a0b, 32'h0c0d0806, 32'h10111213};
    send(w, 2'd1, 60, 1'b0);
    w = '{32'h00002c02, 32'h03040507, 32'h11223344};
    send(w, 2'd2, 0, 1'b0);
    w = '{32'hABCDFFFF, 32'hFFFFFFFF, 32'h55667788, 32'h99AA0806, 32'hCAFEF00D, 32'h01020304};
    send(w, 2'd2, 20, 1'b0);

    // Reset while a frame is mid-payload
    w = '{32'h00002c02, 32'h03040507, 32'h08090a0b, 32'h0c0d0800, 32'hDEAD0001, 32'hDEAD0002};
    send(w, 2'd0, 0, 1'b1);
    do_reset();
    @(posedge clk); #1;

    // Random frames
    for (int k = 0; k < 60; k++) begin
      len = int'($urandom_range(2, 9));
      sel = int'($urandom_range(0, 2));
      dst = (sel == 0) ? LOCAL_MAC : (sel == 1) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), 32'($urandom)};
      sel = int'($urandom_range(0, 2));
      et  = (sel == 0) ? 16'h0800 : (sel == 1) ? 16'h0806 : 16'($urandom);
      w = '{};
      w.push_back({16'($urandom), dst[47:32]});
      w.push_back(dst[31:0]);
      w.push_back($urandom);
      w.push_back({16'($urandom), et});
      for (int p = 4; p < len; p++) w.push_back($urandom);
      while (w.size() > len) void'(w.pop_back());
      send(w, 2'($urandom), ($urandom_range(2) == 0) ? 0 : int'($urandom_range(5, 40)), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("ip_q_drained", 64'(ip_q.size()), 64'd0);
    check("arp_q_drained", 64'(arp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
